// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// RESET_PC_DEFAULT and INSTR_NOP are also used by benches driving the stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response channel plus the IF/ID handoff.
// master = fetch stage side, slave = imem + decode side.
interface if_fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;
  logic [31:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_pcplus4, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_pcplus4, id_instr,
    output id_ready
  );

endinterface

// File: rtl/if_fetch_stage_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} toward decode; flush empties it in one cycle.
// Head is read straight from the storage array so a push is visible the next cycle.
module fetch_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem fetches,
// buffers returned words toward decode and squashes wrong-path fetches on redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  if_fetch_stage_if.master   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_fire;
  logic          rsp_keep;
  logic          id_fire;
  fetch_entry_t  push_entry;
  fetch_entry_t  fifo_head;

  assign redirect_target = word_align(redirect_pc);

  // Credits cover both in-flight requests and buffered words, so a response always has room.
  assign bus.imem_req_valid = !rst && !redirect_valid && (drop_cnt_reg == '0)
                              && ((outstanding_reg + fifo_count) < CW'(DEPTH));
  assign bus.imem_req_addr  = pc_reg;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep           = bus.imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);

  assign bus.id_valid   = !rst && !redirect_valid && !fifo_empty;
  assign id_fire        = bus.id_valid && bus.id_ready;
  assign bus.id_pc      = fifo_head.pc;
  assign bus.id_pcplus4 = fifo_head.pc + 32'd4;
  assign bus.id_instr   = fifo_head.instr;

  assign push_entry = '{pc: rsp_pc_reg, instr: bus.imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (id_fire),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // rsp_pc_reg is the PC of the next kept response: requests within one epoch are
  // sequential and responses arrive in order, so it only ever steps by 4 or jumps on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      assert (!(bus.imem_rsp_valid && fifo_full));
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (redirect_valid) begin
        pc_reg       <= redirect_target;
        rsp_pc_reg   <= redirect_target;
        drop_cnt_reg <= outstanding_reg - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc_reg <= pc_reg + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc_reg <= rsp_pc_reg + 32'd4;
        end else if (bus.imem_rsp_valid) begin
          drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order imem model with variable latency, scoreboard of
// expected {pc, instr} pushed at request acceptance and popped at each decode handshake.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           lat      = 1;
  int           rsp_seen = 0;
  logic [31:0]  exp_pc   = RESET_PC_DEFAULT;
  fetch_entry_t sb [$];
  pend_t        pend [$];
  logic [31:0]  req_log [$];
  logic [31:0]  pop_pc [$];
  logic [31:0]  pop_pc4 [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  // imem model: in-order responses, each no earlier than its due cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = INSTR_NOP;
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst) begin
      sb.delete();
      pend.delete();
      exp_pc = RESET_PC_DEFAULT;
    end else begin
      if (bus.imem_rsp_valid) rsp_seen++;
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        n_checks++;
        if (bus.imem_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL redirect_no_req: imem_req_valid=%b required 0", bus.imem_req_valid);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        $display("req  addr=%h", bus.imem_req_addr);
        n_checks++;
        if (bus.imem_req_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL req_addr: got %h required %h", bus.imem_req_addr, exp_pc);
        end
        req_log.push_back(bus.imem_req_addr);
        sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.id_valid && bus.id_ready) begin
        $display("id   pc=%h pc4=%h instr=%h", bus.id_pc, bus.id_pcplus4, bus.id_instr);
        pop_pc.push_back(bus.id_pc);
        pop_pc4.push_back(bus.id_pcplus4);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL id_unexpected: got pc %h required no instruction", bus.id_pc);
        end else begin
          e = sb.pop_front();
          if (bus.id_pc !== e.pc || bus.id_instr !== e.instr || bus.id_pcplus4 !== e.pc + 32'd4) begin
            n_fail++;
            $display("FAIL id_stream: got pc %h pc4 %h instr %h required pc %h pc4 %h instr %h",
                     bus.id_pc, bus.id_pcplus4, bus.id_instr, e.pc, e.pc + 32'd4, e.instr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int start;
    int k;
    start = pop_pc.size();
    k = 0;
    while (pop_pc.size() < start + n && k < budget) begin
      sample();
      k++;
    end
    n_checks++;
    if (pop_pc.size() < start + n) begin
      n_fail++;
      $display("FAIL %s_timeout: pops %0d required %0d", tag, pop_pc.size() - start, n);
    end
  endtask

  task automatic drain();
    tick();
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (8) sample();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    repeat (3) tick();
    sample();
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got %b required 0", bus.imem_req_valid);
    end
    n_checks++;
    if (bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_id_valid: got %b required 0", bus.id_valid);
    end
    tick();
    rst = 1'b0;
    req_log.delete();
    pop_pc.delete();
    pop_pc4.delete();
    sample();
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC_DEFAULT) begin
      n_fail++;
      $display("FAIL reset_first_req: got valid %b addr %h required 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC_DEFAULT);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] want;
    wait_pops(6, 40, "free_run");
    for (int i = 0; i < 3; i++) begin
      want = RESET_PC_DEFAULT + 32'(4 * i);
      n_checks++;
      if (at(req_log, i) !== want) begin
        n_fail++;
        $display("FAIL free_run_req%0d: got %h required %h", i, at(req_log, i), want);
      end
      n_checks++;
      if (at(pop_pc, i) !== want) begin
        n_fail++;
        $display("FAIL free_run_id_pc%0d: got %h required %h", i, at(pop_pc, i), want);
      end
    end
    n_checks++;
    if (at(pop_pc4, 0) !== 32'h0000_3004) begin
      n_fail++;
      $display("FAIL free_run_pcplus4: got %h required 00003004", at(pop_pc4, 0));
    end
  endtask

  task automatic test_stall();
    tick();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i >= 2) begin
        n_checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_full_c%0d: got req_valid %b id_valid %b required 0 1",
                   i, bus.imem_req_valid, bus.id_valid);
        end
        n_checks++;
        if (sb.size() != 2) begin
          n_fail++;
          $display("FAIL stall_credits_c%0d: got %0d in flight required 2", i, sb.size());
        end
      end
    end
    tick();
    bus.id_ready = 1'b1;
    wait_pops(6, 40, "stall_release");
  endtask

  task automatic test_redirect_outstanding();
    int rs;
    int k;
    int start;
    drain();
    tick();
    lat = 4;
    bus.imem_req_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (sb.size() != 2 || bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_setup: got outstanding %0d id_valid %b required 2 0", sb.size(), bus.id_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4001;
    sample();
    n_checks++;
    if (bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_id_valid: got %b required 0", bus.id_valid);
    end
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    rs = rsp_seen;
    k = 0;
    sample();
    while (bus.imem_req_valid !== 1'b1 && k < 20) begin
      sample();
      k++;
    end
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL redir_next_req: got valid %b addr %h required 1 00004000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    n_checks++;
    if (rsp_seen - rs != 2) begin
      n_fail++;
      $display("FAIL redir_dropped: got %0d responses before resume required 2", rsp_seen - rs);
    end
    start = pop_pc.size();
    wait_pops(1, 20, "redir_resume");
    n_checks++;
    if (at(pop_pc, start) !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL redir_first_id: got %h required 00004000", at(pop_pc, start));
    end
  endtask

  task automatic test_redirect_with_rsp();
    int pops;
    int start;
    drain();
    tick();
    bus.imem_req_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_redir_setup: id_valid %b required 1", bus.id_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    pops = pop_pc.size();
    sample();
    n_checks++;
    if (bus.id_valid !== 1'b0 || bus.imem_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_redir_cycle: got id_valid %b rsp_valid %b required 0 1",
               bus.id_valid, bus.imem_rsp_valid);
    end
    n_checks++;
    if (pop_pc.size() != pops) begin
      n_fail++;
      $display("FAIL rsp_redir_pop: got %0d pops required 0", pop_pc.size() - pops);
    end
    tick();
    redirect_valid = 1'b0;
    sample();
    n_checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL rsp_redir_resume: got valid %b addr %h required 1 00005000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    start = pop_pc.size();
    wait_pops(2, 20, "rsp_redir_stream");
    n_checks++;
    if (at(pop_pc, start) !== 32'h0000_5000 || at(pop_pc, start + 1) !== 32'h0000_5004) begin
      n_fail++;
      $display("FAIL rsp_redir_stream: got %h %h required 00005000 00005004",
               at(pop_pc, start), at(pop_pc, start + 1));
    end
  endtask

  task automatic test_req_ready_low();
    int k;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req_log.delete();
    k = 0;
    while (req_log.size() < 2 && k < 20) begin
      sample();
      k++;
    end
    n_checks++;
    if (req_log.size() < 2) begin
      n_fail++;
      $display("FAIL hold_setup: got %0d requests required 2", req_log.size());
    end
    tick();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_checks++;
      if (bus.imem_req_addr !== 32'h0000_3008) begin
        n_fail++;
        $display("FAIL hold_addr_c%0d: got %h required 00003008", i, bus.imem_req_addr);
      end
    end
    n_checks++;
    if (req_log.size() != 2) begin
      n_fail++;
      $display("FAIL hold_no_accept: got %0d requests required 2", req_log.size());
    end
    tick();
    bus.imem_req_ready = 1'b1;
    k = 0;
    while (req_log.size() < 4 && k < 20) begin
      sample();
      k++;
    end
    n_checks++;
    if (at(req_log, 2) !== 32'h0000_3008 || at(req_log, 3) !== 32'h0000_300C) begin
      n_fail++;
      $display("FAIL hold_advance: got %h %h required 00003008 0000300c",
               at(req_log, 2), at(req_log, 3));
    end
  endtask

  task automatic test_wrap_reset();
    int start;
    int k;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    start = pop_pc.size();
    wait_pops(2, 30, "wrap");
    n_checks++;
    if (at(pop_pc, start) !== 32'hFFFF_FFFC || at(pop_pc4, start) !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_first: got pc %h pc4 %h required fffffffc 00000000",
               at(pop_pc, start), at(pop_pc4, start));
    end
    n_checks++;
    if (at(pop_pc, start + 1) !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_second: got %h required 00000000", at(pop_pc, start + 1));
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++;
      if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_c%0d: got id_valid %b req_valid %b required 0 0",
                 i, bus.id_valid, bus.imem_req_valid);
      end
    end
    tick();
    rst = 1'b0;
    req_log.delete();
    k = 0;
    while (req_log.size() < 1 && k < 10) begin
      sample();
      k++;
    end
    n_checks++;
    if (at(req_log, 0) !== RESET_PC_DEFAULT) begin
      n_fail++;
      $display("FAIL midrst_first_req: got %h required %h", at(req_log, 0), RESET_PC_DEFAULT);
    end
    wait_pops(3, 20, "midrst_stream");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_outstanding();
    test_redirect_with_rsp();
    test_req_ready_low();
    test_wrap_reset();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

endmodule
